// File: rtl/sisc_exec_ctrl_if.sv
// rtl/sisc_exec_ctrl_if.sv - datapath/control signal bundle between the SISC execution core and its datapath
interface sisc_exec_ctrl_if;
    logic [31:0] instr;
    logic [15:0] pc;
    logic [31:0] rsa;
    logic [31:0] rsb;
    logic [3:0]  stat_in;
    logic [31:0] alu_result;
    logic [3:0]  cc;
    logic        stat_en;
    logic [15:0] br_addr;
    logic        rf_we;
    logic        rb_sel;
    logic        swap_sel;
    logic        pc_sel;
    logic        pc_write;
    logic        pc_rst;
    logic        ir_load;
    logic        dm_we;
    logic        addr_sel;
    logic [1:0]  wb_sel;
    logic [31:0] swap_tmp;
    logic        halted;

    modport master (
        input  instr, pc, rsa, rsb, stat_in,
        output alu_result, cc, stat_en, br_addr, rf_we, rb_sel, swap_sel, pc_sel,
               pc_write, pc_rst, ir_load, dm_we, addr_sel, wb_sel, swap_tmp, halted
    );

    modport slave (
        output instr, pc, rsa, rsb, stat_in,
        input  alu_result, cc, stat_en, br_addr, rf_we, rb_sel, swap_sel, pc_sel,
               pc_write, pc_rst, ir_load, dm_we, addr_sel, wb_sel, swap_tmp, halted
    );
endinterface

// File: rtl/sisc_exec_ctrl.sv
// rtl/sisc_exec_ctrl.sv - SISC multicycle control FSM, 32-bit ALU and branch-target generator (SWAP op enabled by SISC_SWAP_EN)
module sisc_exec_ctrl (
    input  logic             clk,
    input  logic             rst_f,
    sisc_exec_ctrl_if.master bus
);
    localparam logic [3:0] OP_REG_OP = 4'h1;
    localparam logic [3:0] OP_SWAP   = 4'h2;
    localparam logic [3:0] OP_BRA    = 4'h4;
    localparam logic [3:0] OP_BRR    = 4'h5;
    localparam logic [3:0] OP_BNE    = 4'h6;
    localparam logic [3:0] OP_BNR    = 4'h7;
    localparam logic [3:0] OP_JPA    = 4'h8;
    localparam logic [3:0] OP_JPR    = 4'h9;
    localparam logic [3:0] OP_LOD    = 4'hA;
    localparam logic [3:0] OP_STR    = 4'hB;
    localparam logic [3:0] OP_HLT    = 4'hE;
    localparam logic [3:0] OP_REG_IM = 4'hF;

    localparam logic [3:0] F_ADD  = 4'h1;
    localparam logic [3:0] F_SUB  = 4'h2;
    localparam logic [3:0] F_NOT  = 4'h3;
    localparam logic [3:0] F_OR   = 4'h4;
    localparam logic [3:0] F_AND  = 4'h5;
    localparam logic [3:0] F_XOR  = 4'h6;
    localparam logic [3:0] F_ROTL = 4'h7;
    localparam logic [3:0] F_SHL  = 4'h8;
    localparam logic [3:0] F_SHR  = 4'h9;
    localparam logic [3:0] F_SRA  = 4'hA;

`ifdef SISC_SWAP_EN
    localparam logic SWAP_EN = 1'b1;
`else
    localparam logic SWAP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_START, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_WB2, S_HALT
    } state_t;

    state_t state, state_nxt;

    logic [3:0]  op, mm;
    logic [15:0] imm;
    logic        is_alu_op, is_mem, is_swap;

    assign op        = bus.instr[31:28];
    assign mm        = bus.instr[27:24];
    assign imm       = bus.instr[15:0];
    assign is_alu_op = (op == OP_REG_OP) || (op == OP_REG_IM);
    assign is_mem    = (op == OP_LOD) || (op == OP_STR);
    assign is_swap   = SWAP_EN && (op == OP_SWAP);

    // Register-indirect LOD/STR reuse the adder for rsa+imm, so the function is forced to ADD
    logic [31:0] opa, opb;
    logic [3:0]  funct;

    assign opa   = bus.rsa;
    assign opb   = (op == OP_REG_OP) ? bus.rsb : {{16{imm[15]}}, imm};
    assign funct = (is_mem && mm[0]) ? F_ADD : mm;

    logic [32:0] sum, diff;
    logic [31:0] res;
    logic [4:0]  shamt;
    logic        c_flag, v_flag, flags_on;

    assign shamt = opb[4:0];

    // ALU: result plus carry/overflow; unknown functions pass rsa through with all flags cleared
    always_comb begin
        sum      = {1'b0, opa} + {1'b0, opb};
        diff     = {1'b0, opa} + {1'b0, ~opb} + 33'd1;
        res      = opa;
        c_flag   = 1'b0;
        v_flag   = 1'b0;
        flags_on = 1'b1;
        case (funct)
            F_ADD: begin
                res    = sum[31:0];
                c_flag = sum[32];
                v_flag = (opa[31] == opb[31]) && (sum[31] != opa[31]);
            end
            F_SUB: begin
                res    = diff[31:0];
                c_flag = diff[32];
                v_flag = (opa[31] != opb[31]) && (diff[31] != opa[31]);
            end
            F_NOT:   res = ~opa;
            F_OR:    res = opa | opb;
            F_AND:   res = opa & opb;
            F_XOR:   res = opa ^ opb;
            F_ROTL:  res = (opa << shamt) | (opa >> (6'd32 - {1'b0, shamt}));
            F_SHL:   res = opa << shamt;
            F_SHR:   res = opa >> shamt;
            F_SRA:   res = $unsigned($signed(opa) >>> shamt);
            default: flags_on = 1'b0;
        endcase
    end

    assign bus.alu_result = res;
    assign bus.cc         = flags_on ? {c_flag, res[31], v_flag, (res == 32'd0)} : 4'b0000;

    logic taken, relative;

    // Branch condition against the status register and absolute/relative target select
    always_comb begin
        taken    = 1'b0;
        relative = (op == OP_BRR) || (op == OP_BNR) || (op == OP_JPR);
        case (op)
            OP_BRA, OP_BRR: taken = |(mm & bus.stat_in);
            OP_BNE, OP_BNR: taken = ~|(mm & bus.stat_in);
            OP_JPA, OP_JPR: taken = 1'b1;
            default:        taken = 1'b0;
        endcase
    end

    assign bus.br_addr = relative ? (bus.pc + imm) : imm;

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) state <= S_START;
        else        state <= state_nxt;
    end

    logic       rf_we, rb_sel, swap_sel, pc_sel, pc_write, pc_rst;
    logic       ir_load, dm_we, addr_sel, stat_en;
    logic [1:0] wb_sel;

    // Next state and per-state datapath strobes
    always_comb begin
        state_nxt = state;
        rf_we     = 1'b0;
        rb_sel    = 1'b0;
        swap_sel  = 1'b0;
        pc_sel    = 1'b0;
        pc_write  = 1'b0;
        pc_rst    = 1'b0;
        ir_load   = 1'b0;
        dm_we     = 1'b0;
        addr_sel  = 1'b0;
        stat_en   = 1'b0;
        wb_sel    = 2'd0;
        case (state)
            S_START: begin
                pc_rst    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                ir_load   = 1'b1;
                pc_write  = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (op == OP_HLT) begin
                    state_nxt = S_HALT;
                end else begin
                    state_nxt = S_EXEC;
                    if (taken) begin
                        pc_sel   = 1'b1;
                        pc_write = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                stat_en   = is_alu_op;
                rb_sel    = (op == OP_STR) || is_swap;
                addr_sel  = is_mem && mm[0];
                state_nxt = S_MEM;
            end
            S_MEM: begin
                dm_we     = (op == OP_STR);
                rb_sel    = (op == OP_STR);
                addr_sel  = is_mem && mm[0];
                state_nxt = S_WB;
            end
            S_WB: begin
                if (is_alu_op) begin
                    rf_we = 1'b1;
                end else if (op == OP_LOD) begin
                    rf_we    = 1'b1;
                    wb_sel   = 2'd1;
                    addr_sel = mm[0];
                end else if (is_swap) begin
                    rf_we  = 1'b1;
                    wb_sel = 2'd2;
                end
                state_nxt = is_swap ? S_WB2 : S_FETCH;
            end
            S_WB2: begin
                rf_we     = 1'b1;
                swap_sel  = 1'b1;
                wb_sel    = 2'd3;
                state_nxt = S_FETCH;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_START;
        endcase
    end

    assign bus.rf_we    = rf_we;
    assign bus.rb_sel   = rb_sel;
    assign bus.swap_sel = swap_sel;
    assign bus.pc_sel   = pc_sel;
    assign bus.pc_write = pc_write;
    assign bus.pc_rst   = pc_rst;
    assign bus.ir_load  = ir_load;
    assign bus.dm_we    = dm_we;
    assign bus.addr_sel = addr_sel;
    assign bus.stat_en  = stat_en;
    assign bus.wb_sel   = wb_sel;
    assign bus.halted   = (state == S_HALT);

`ifdef SISC_SWAP_EN
    logic [31:0] swap_tmp;

    // Hold R[rs] across WB so WB2 can write it into R[rd]'s old partner
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f)                          swap_tmp <= 32'd0;
        else if (state == S_EXEC && is_swap) swap_tmp <= bus.rsb;
    end

    assign bus.swap_tmp = swap_tmp;
`else
    assign bus.swap_tmp = 32'd0;
`endif
endmodule

// File: tb/tb_sisc_exec_ctrl.sv
// tb/tb_sisc_exec_ctrl.sv - self-checking bench for sisc_exec_ctrl with a behavioural ALU/branch/sequence model
module tb_sisc_exec_ctrl;
    logic clk = 1'b0;
    logic rst_f;

    sisc_exec_ctrl_if bus ();

    sisc_exec_ctrl dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef SISC_SWAP_EN
    localparam bit SWAP_EN = 1'b1;
`else
    localparam bit SWAP_EN = 1'b0;
`endif

    localparam int B_RF = 12;
    localparam int B_RB = 11;
    localparam int B_SW = 10;
    localparam int B_PS = 9;
    localparam int B_PW = 8;
    localparam int B_PR = 7;
    localparam int B_IR = 6;
    localparam int B_DM = 5;
    localparam int B_AS = 4;
    localparam int B_SE = 3;
    localparam int B_HA = 2;
    localparam logic [12:0] MASK_ALL = 13'h1FFF;
    localparam logic [12:0] MASK_MID = 13'h1FFF & ~(13'd1 << B_RB) & ~(13'd1 << B_AS);

    int checks = 0;
    int errors = 0;

    logic [12:0] cap_dec, cap_mem, e;
    logic [31:0] cap_alu;
    logic [3:0]  cap_cc;
    logic [15:0] cap_br;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] strobes();
        return {bus.rf_we, bus.rb_sel, bus.swap_sel, bus.pc_sel, bus.pc_write, bus.pc_rst,
                bus.ir_load, bus.dm_we, bus.addr_sel, bus.stat_en, bus.halted, bus.wb_sel};
    endfunction

    task automatic chk_phase(input string tag, input logic [12:0] exp, input logic [12:0] mask);
        chk(tag, {19'd0, strobes() & mask}, {19'd0, exp & mask});
    endtask

    // Reference ALU from arithmetic definitions: returns {C,N,V,Z,result}
    function automatic logic [35:0] alu_model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, wide;
        logic [31:0] r;
        logic c, v;
        int n;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        r = a; c = 1'b0; v = 1'b0; n = int'(b[4:0]);
        case (f)
            4'h1: begin
                r = a + b;
                c = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
                wide = sa + sb;
                v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'h2: begin
                r = a - b;
                c = (a >= b);
                wide = sa - sb;
                v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'h3: r = ~a;
            4'h4: r = a | b;
            4'h5: r = a & b;
            4'h6: r = a ^ b;
            4'h7: for (int i = 0; i < n; i++) r = {r[30:0], r[31]};
            4'h8: for (int i = 0; i < n; i++) r = {r[30:0], 1'b0};
            4'h9: for (int i = 0; i < n; i++) r = {1'b0, r[31:1]};
            4'hA: for (int i = 0; i < n; i++) r = {r[31], r[31:1]};
            default: return {4'b0000, a};
        endcase
        return {c, r[31], v, (r == 32'd0), r};
    endfunction

    // Drive one instruction and check every phase it passes through
    task automatic run_instr(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] rd,
                             input logic [3:0] rs, input logic [15:0] imm, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] st, input logic [15:0] pcv);
        logic [12:0] ex, m;
        logic        taken, is_br, alu_op, mem_op, swp;
        logic [15:0] br;
        logic [35:0] ref_alu;
        logic [31:0] opb;
        bus.instr   = {op, mm, rd, rs, imm};
        bus.rsa     = a;
        bus.rsb     = b;
        bus.stat_in = st;
        bus.pc      = pcv;
        is_br  = (op >= 4'h4) && (op <= 4'h9);
        case (op)
            4'h4, 4'h5: taken = (mm & st) != 4'd0;
            4'h6, 4'h7: taken = (mm & st) == 4'd0;
            4'h8, 4'h9: taken = 1'b1;
            default:    taken = 1'b0;
        endcase
        br     = (op == 4'h4 || op == 4'h6 || op == 4'h8) ? imm : 16'(pcv + imm);
        alu_op = (op == 4'h1) || (op == 4'hF);
        mem_op = (op == 4'hA) || (op == 4'hB);
        swp    = SWAP_EN && (op == 4'h2);

        @(negedge clk);
        ex = '0; ex[B_IR] = 1'b1; ex[B_PW] = 1'b1;
        chk_phase("fetch", ex, MASK_ALL);

        @(negedge clk);
        ex = '0;
        if (taken) begin ex[B_PS] = 1'b1; ex[B_PW] = 1'b1; end
        chk_phase("decode", ex, MASK_MID);
        cap_dec = strobes();
        cap_br  = bus.br_addr;
        if (is_br) chk("br_addr", 32'(bus.br_addr), 32'(br));
        if (op == 4'hE) begin
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                ex = '0; ex[B_HA] = 1'b1;
                chk_phase("halt", ex, MASK_ALL);
            end
            return;
        end

        @(negedge clk);
        ex = '0; m = MASK_MID; ex[B_SE] = alu_op;
        if (op == 4'h1 || swp) begin m[B_RB] = 1'b1; ex[B_RB] = swp; end
        chk_phase("exec", ex, m);
        cap_alu = bus.alu_result;
        cap_cc  = bus.cc;
        if (alu_op) begin
            opb = (op == 4'h1) ? b : {{16{imm[15]}}, imm};
            ref_alu = alu_model(mm, a, opb);
            chk("alu_result", bus.alu_result, ref_alu[31:0]);
            chk("alu_cc", 32'(bus.cc), 32'(ref_alu[35:32]));
        end
        if (mem_op && mm[0]) chk("addr_calc", 32'(bus.alu_result[15:0]), 32'(16'(a[15:0] + imm)));

        @(negedge clk);
        ex = '0; m = MASK_MID; ex[B_DM] = (op == 4'hB);
        if (mem_op) begin m[B_AS] = 1'b1; ex[B_AS] = mm[0]; end
        if (op == 4'hB) begin m[B_RB] = 1'b1; ex[B_RB] = 1'b1; end
        chk_phase("mem", ex, m);
        cap_mem = strobes();

        @(negedge clk);
        ex = '0;
        ex[B_RF]  = alu_op || (op == 4'hA) || swp;
        ex[1:0]   = (op == 4'hA) ? 2'd1 : (swp ? 2'd2 : 2'd0);
        chk_phase("wb", ex, MASK_MID);
        if (swp) begin
            chk("swap_tmp_wb", bus.swap_tmp, b);
            @(negedge clk);
            ex = '0; ex[B_RF] = 1'b1; ex[B_SW] = 1'b1; ex[1:0] = 2'd3;
            chk_phase("wb2", ex, MASK_MID);
            chk("swap_tmp_wb2", bus.swap_tmp, b);
        end else if (op == 4'h2) begin
            chk("swap_tmp_off", bus.swap_tmp, 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rop;
        rst_f       = 1'b0;
        bus.instr   = 32'd0;
        bus.pc      = 16'd0;
        bus.rsa     = 32'd0;
        bus.rsb     = 32'd0;
        bus.stat_in = 4'd0;

        repeat (2) @(negedge clk);
        e = '0; e[B_PR] = 1'b1;
        chk_phase("reset_strobes", e, MASK_ALL);
        chk("reset_swap_tmp", bus.swap_tmp, 32'd0);
        rst_f = 1'b1;

        run_instr(4'h1, 4'h1, 4'h3, 4'h4, 16'h5000, 32'h7FFF_FFFF, 32'h1, 4'h0, 16'h0010);
        chk("add_ovf_result", cap_alu, 32'h8000_0000);
        chk("add_ovf_cc", 32'(cap_cc), 32'(4'b0110));

        run_instr(4'hF, 4'h2, 4'h1, 4'h2, 16'h0005, 32'h5, 32'h0, 4'h0, 16'h0011);
        chk("subi_zero_result", cap_alu, 32'h0);
        chk("subi_zero_cc", 32'(cap_cc), 32'(4'b1001));

        run_instr(4'hF, 4'h2, 4'h1, 4'h2, 16'hFFFF, 32'h5, 32'h0, 4'h0, 16'h0012);
        chk("subi_neg1_result", cap_alu, 32'h6);
        chk("subi_neg1_cc", 32'(cap_cc), 32'(4'b0000));

        run_instr(4'h5, 4'h1, 4'h0, 4'h0, 16'hFFF0, 32'h0, 32'h0, 4'h1, 16'h0010);
        chk("brr_wrap_target", 32'(cap_br), 32'h0);
        chk("brr_taken_pc_write", 32'(cap_dec[B_PW]), 32'd1);
        chk("brr_taken_pc_sel", 32'(cap_dec[B_PS]), 32'd1);

        run_instr(4'h5, 4'h1, 4'h0, 4'h0, 16'hFFF0, 32'h0, 32'h0, 4'h0, 16'h0010);
        chk("brr_not_taken_pc_write", 32'(cap_dec[B_PW]), 32'd0);

        run_instr(4'hB, 4'h1, 4'h6, 4'h7, 16'h0004, 32'h0000_0100, 32'hDEAD_BEEF, 4'h0, 16'h0020);
        chk("str_addr", cap_alu, 32'h104);
        chk("str_addr_sel", 32'(cap_mem[B_AS]), 32'd1);
        chk("str_dm_we", 32'(cap_mem[B_DM]), 32'd1);

        run_instr(4'h2, 4'h0, 4'h3, 4'h5, 16'h0000, 32'hAAAA_0001, 32'hBBBB_0002, 4'h0, 16'h0030);

        for (int k = 0; k < 40; k++) begin
            rop = 4'($urandom_range(0, 15));
            if (rop == 4'hE) rop = 4'h1;
            run_instr(rop, 4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom),
                      $urandom, $urandom, 4'($urandom), 16'($urandom));
        end

        bus.instr = {4'h1, 4'h1, 4'h2, 4'h3, 16'h4000};
        repeat (3) @(negedge clk);
        rst_f = 1'b0;
        #1;
        e = '0; e[B_PR] = 1'b1;
        chk_phase("reset_mid_exec", e, MASK_ALL);
        @(negedge clk);
        chk_phase("reset_held", e, MASK_ALL);
        rst_f = 1'b1;

        run_instr(4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 32'h0, 32'h0, 4'h0, 16'h0001);
        run_instr(4'hE, 4'h0, 4'h0, 4'h0, 16'h0000, 32'h0, 32'h0, 4'h0, 16'h0002);

        rst_f = 1'b0;
        #1;
        chk_phase("reset_exits_halt", e, MASK_ALL);
        @(negedge clk);
        rst_f = 1'b1;
        run_instr(4'hA, 4'h0, 4'h1, 4'h0, 16'h0040, 32'h0, 32'h0, 4'h0, 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
